input_conditioner: RTL and testbench

- Upstream stage of edge_detection. Takes a raw, asynchronous, possibly bouncing level input and produces a clean, synchronous, debounced level for edge_detection's din.
- Structure: an N-flop synchronizer, then a debounce state machine with a stability counter.
- Also reports when a debounce is pending and when a pending transition is aborted as a glitch.

---
 rtl/input_conditioner.sv | 112 +++++++++++
 tb/tb_input_conditioner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Conditions a raw asynchronous level: an N-flop synchronizer, then a debounce
// FSM that needs DEBOUNCE_CYCLES consecutive samples at the new level.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_async,
  output logic dout,
  output logic busy,
  output logic glitch
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] PEND_HI = 2'd1;
  localparam logic [1:0] IDLE_HI = 2'd2;
  localparam logic [1:0] PEND_LO = 2'd3;
  localparam logic [1:0] RST_ST  = RESET_VAL ? IDLE_HI : IDLE_LO;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   din_s;
  logic [1:0]             state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic                   dout_n, busy_n, glitch_n;

  // Plain flop chain: nothing may sit between synchronizer stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din_async};
  end

  assign din_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dout_n   = dout;
    glitch_n = 1'b0;
    case (state)
      IDLE_LO:
        if (din_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n = IDLE_HI;
            dout_n  = 1'b1;
          end else begin
            state_n = PEND_HI;
            cnt_n   = CNT_W'(1);
          end
        end
      PEND_HI:
        if (!din_s) begin
          state_n  = IDLE_LO;
          cnt_n    = '0;
          glitch_n = 1'b1;
        end else if (cnt == CNT_MAX) begin
          state_n = IDLE_HI;
          dout_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      IDLE_HI:
        if (!din_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n = IDLE_LO;
            dout_n  = 1'b0;
          end else begin
            state_n = PEND_LO;
            cnt_n   = CNT_W'(1);
          end
        end
      PEND_LO:
        if (din_s) begin
          state_n  = IDLE_HI;
          cnt_n    = '0;
          glitch_n = 1'b1;
        end else if (cnt == CNT_MAX) begin
          state_n = IDLE_LO;
          dout_n  = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      default: begin
        state_n = RST_ST;
        cnt_n   = '0;
        dout_n  = RESET_VAL;
      end
    endcase
    busy_n = (state_n == PEND_HI) || (state_n == PEND_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RST_ST;
      cnt    <= '0;
      dout   <= RESET_VAL;
      busy   <= 1'b0;
      glitch <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      dout   <= dout_n;
      busy   <= busy_n;
      glitch <= glitch_n;
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// Directed + random stimulus for input_conditioner; a history-based reference
// model pushes expected {dout,busy,glitch} per edge, a monitor pops and compares.
module tb_input_conditioner;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din_async = 1'b1;
  logic dout, busy, glitch;
  logic dout1, busy1, glitch1;

  int checks = 0;
  int errors = 0;
  int rises = 0;
  int glitches = 0;

  logic [2:0] expq[$];

  always #5 clk = ~clk;

  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(D), .RESET_VAL(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .din_async(din_async),
    .dout(dout), .busy(busy), .glitch(glitch)
  );

  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VAL(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din_async(din_async),
    .dout(dout1), .busy(busy1), .glitch(glitch1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: dout takes value v once the last D synchronized samples are all v;
  // a pending debounce is any sample that differs from the settled dout.
  initial begin
    logic s1, s2, ds, prev, old_dout, old_busy, m_dout, m_busy, m_glitch;
    int run;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        s1 = 0; s2 = 0; prev = 0; run = 0;
        m_dout = 0; m_busy = 0; m_glitch = 0;
        expq.delete();
      end else begin
        ds = s2; s2 = s1; s1 = din_async;
        run = (ds == prev) ? run + 1 : 1;
        prev = ds;
        old_dout = m_dout;
        old_busy = m_busy;
        if (run >= D) m_dout = ds;
        m_busy   = (ds != m_dout);
        m_glitch = old_busy && (ds == old_dout);
        expq.push_back({m_dout, m_busy, m_glitch});
      end
    end
  end

  initial begin
    logic [2:0] e;
    logic pd;
    pd = 0;
    forever begin
      @(negedge clk);
      if (rst_n && expq.size() > 0) begin
        e = expq.pop_front();
        chk("dout", 32'(dout), 32'(e[2]));
        chk("busy", 32'(busy), 32'(e[1]));
        chk("glitch", 32'(glitch), 32'(e[0]));
        chk("busy_d1", 32'(busy1), 32'd0);
        chk("glitch_d1", 32'(glitch1), 32'd0);
      end
      if (glitch) glitches++;
      if (dout && !pd) rises++;
      pd = dout;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_glitch"}, 32'(glitch), 32'd0);
  endtask

  initial begin
    int g0, r0;
    // 1: reset held with din high, then async reset mid-debounce
    cyc(3);
    chk_reset_outs("rst_hold");
    rst_n = 1'b1;
    cyc(4);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("rst_async");
    chk("rst_async_d1", 32'(dout1), 32'd0);
    din_async = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(4);

    // 2: clean rise; D=1 instance follows at edge k+2
    g0 = glitches; r0 = rises;
    din_async = 1'b1;
    cyc(1); chk("d1_k", 32'(dout1), 32'd0);
    cyc(1); chk("d1_k1", 32'(dout1), 32'd0);
    cyc(1); chk("d1_k2", 32'(dout1), 32'd1);
    cyc(6);
    chk("rise_dout", 32'(dout), 32'd1);
    chk("rise_noglitch", 32'(glitches - g0), 32'd0);
    chk("rise_once", 32'(rises - r0), 32'd1);

    // 5a: clean fall
    din_async = 1'b0;
    cyc(8);
    chk("fall_dout", 32'(dout), 32'd0);
    chk("fall_d1", 32'(dout1), 32'd0);

    // 3: bounce 2 high, 1 low, then steady high
    g0 = glitches; r0 = rises;
    din_async = 1'b1; cyc(2);
    din_async = 1'b0; cyc(1);
    din_async = 1'b1; cyc(10);
    chk("bounce_glitch", 32'(glitches - g0), 32'd1);
    chk("bounce_rise", 32'(rises - r0), 32'd1);
    din_async = 1'b0; cyc(8);

    // 4: exactly D high is accepted, D-1 high is rejected
    g0 = glitches; r0 = rises;
    din_async = 1'b1; cyc(D);
    din_async = 1'b0; cyc(10);
    chk("pulse4_rise", 32'(rises - r0), 32'd1);
    chk("pulse4_noglitch", 32'(glitches - g0), 32'd0);
    r0 = rises;
    din_async = 1'b1; cyc(D - 1);
    din_async = 1'b0; cyc(10);
    chk("pulse3_rise", 32'(rises - r0), 32'd0);
    chk("pulse3_glitch", 32'(glitches - g0), 32'd1);

    // back-to-back aborts: alternating single samples
    g0 = glitches;
    repeat (3) begin
      din_async = 1'b1; cyc(1);
      din_async = 1'b0; cyc(1);
    end
    cyc(6);
    chk("b2b_glitch", 32'(glitches - g0), 32'd3);

    // 5b: reset during PEND_LO
    din_async = 1'b1; cyc(8);
    chk("pre_pl_dout", 32'(dout), 32'd1);
    g0 = glitches;
    din_async = 1'b0; cyc(3);
    chk("pl_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("rst_pl");
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    chk("rst_pl_noglitch", 32'(glitches - g0), 32'd0);

    // random bouncy input against the model
    repeat (300) begin
      din_async = ($urandom_range(0, 3) == 0) ? ~din_async : din_async;
      cyc(1);
    end
    cyc(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
